// File: rtl/dtm_dmi_ctrl.sv
// DTM-side DMI initiator: turns TAP DMI updates into DM request/response
// transactions and keeps the sticky op status reported on the next capture.
module dtm_dmi_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       sys_clk,
    input  logic                       sys_rstn,
    input  logic                       dmi_update,
    input  logic [ADDR_W+DATA_W+1:0]   dmi_wdata,
    input  logic                       dmi_capture,
    output logic [ADDR_W+DATA_W+1:0]   dmi_rdata,
    input  logic                       dmireset,
    input  logic                       dmihardreset,
    output logic                       dtm_req_valid,
    input  logic                       dtm_req_ready,
    output logic [ADDR_W+DATA_W+1:0]   dtm_req_bits,
    input  logic                       dm_resp_valid,
    output logic                       dm_resp_ready,
    input  logic [DATA_W+1:0]          dm_resp_bits,
    output logic                       dmi_busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state;
    logic [1:0]          sticky;
    logic [15:0]         cnt;
    logic [DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]   last_addr;

    logic [1:0]          upd_op;
    logic [DATA_W-1:0]   upd_data;
    logic [ADDR_W-1:0]   upd_addr;
    logic                upd_rw;
    logic                resp_fail;
    logic                tmo;
    logic [1:0]          status;

    assign upd_op    = dmi_wdata[1:0];
    assign upd_data  = dmi_wdata[DATA_W+1:2];
    assign upd_addr  = dmi_wdata[ADDR_W+DATA_W+1:DATA_W+2];
    assign upd_rw    = (upd_op == 2'd1) || (upd_op == 2'd2);
    assign resp_fail = (state == RESP) && dm_resp_valid && (dm_resp_bits[1:0] >= 2'd2);
    // A response in the final RESP cycle beats the timeout.
    assign tmo       = (state == RESP) && !dm_resp_valid && (cnt == 16'(TIMEOUT - 1));

    assign status    = (sticky != 2'd0) ? sticky : (dmi_busy ? 2'd3 : 2'd0);
    assign dmi_rdata = {last_addr, rd_data, status};

    // Clears win over any same-cycle set; a failure outranks a busy report.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn)
            sticky <= 2'd0;
        else if (dmihardreset || dmireset)
            sticky <= 2'd0;
        else if (resp_fail || tmo)
            sticky <= 2'd2;
        else if ((state != IDLE) && (dmi_update || (dmi_capture && sticky == 2'd0)))
            sticky <= 2'd3;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state         <= IDLE;
            cnt           <= '0;
            dtm_req_valid <= 1'b0;
            dm_resp_ready <= 1'b0;
            dmi_busy      <= 1'b0;
            dtm_req_bits  <= '0;
            rd_data       <= '0;
            last_addr     <= '0;
        end else if (dmihardreset) begin
            state         <= IDLE;
            cnt           <= '0;
            dtm_req_valid <= 1'b0;
            dm_resp_ready <= 1'b0;
            dmi_busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmi_update && upd_rw && sticky == 2'd0) begin
                        dtm_req_bits  <= {upd_data, upd_addr, upd_op};
                        last_addr     <= upd_addr;
                        dtm_req_valid <= 1'b1;
                        dmi_busy      <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (dtm_req_ready) begin
                        dtm_req_valid <= 1'b0;
                        dm_resp_ready <= 1'b1;
                        cnt           <= '0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (dm_resp_valid || tmo) begin
                        dm_resp_ready <= 1'b0;
                        dmi_busy      <= 1'b0;
                        state         <= IDLE;
                        // Writes keep the previously read data visible.
                        if (dm_resp_valid && dtm_req_bits[1:0] == 2'd1)
                            rd_data <= dm_resp_bits[DATA_W+1:2];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dtm_dmi_ctrl.md
# dtm_dmi_ctrl

Debug Transport Module (DTM) side initiator of the DMI bus. It turns DMI register updates from the JTAG TAP logic into request/response transactions with the Debug Module. It also latches the returned data and maintains the sticky `op` status (success / failed / busy) that the debugger sees on the next DMI capture. The block sits between the JTAG DTM TAP datapath and the Debug Module register block, on the same `sys_clk`. TAP-side strobes arrive already synchronized to `sys_clk`.

## Interface
Parameters:
- `ADDR_W`, 7: DMI address width.
- `DATA_W`, 32: DMI data width.
- `TIMEOUT`, 255: maximum cycles to wait for `dm_resp_valid` before the transaction is failed. Must be 1..65535.

Ports:
- `sys_clk`  in  1  single clock.
- `sys_rstn`  in  1  reset, asynchronous, active-low.
- `dmi_update`  in  1  one-cycle pulse; `dmi_wdata` holds a new DMI request.
- `dmi_wdata`  in  ADDR_W+DATA_W+2  fields: [1:0] op, [DATA_W+1:2] data, [top:DATA_W+2] addr.
- `dmi_capture`  in  1  one-cycle pulse; the TAP samples `dmi_rdata` this cycle.
- `dmi_rdata`  out  ADDR_W+DATA_W+2  fields: [1:0] status, [DATA_W+1:2] last read data, [top:DATA_W+2] last address.
- `dmireset`  in  1  pulse; clears the sticky status.
- `dmihardreset`  in  1  pulse; aborts any transaction, returns to IDLE, clears the sticky status.
- `dtm_req_valid`  out  1  request valid.
- `dtm_req_ready`  in  1  DM accepts the request.
- `dtm_req_bits`  out  `DBUS_M_WIDTH`  request: [1:0] op, [ADDR_W+1:2] addr, [top:ADDR_W+2] data. `DBUS_M_WIDTH` = ADDR_W+DATA_W+2.
- `dm_resp_valid`  in  1  response valid.
- `dm_resp_ready`  out  1  DTM accepts the response.
- `dm_resp_bits`  in  `DBUS_S_WIDTH`  response: [1:0] op status, [DATA_W+1:2] data.
- `dmi_busy`  out  1  a transaction is in flight (state ≠ IDLE).

## Operation
- Op encoding on `dmi_wdata`: 0 nop, 1 read, 2 write, 3 reserved (treated as nop).
- Status encoding on `dmi_rdata`: 0 success, 2 failed, 3 busy.
- FSM has three states: IDLE, REQ and RESP.
- IDLE:
  - `dmi_update` with op 1 or 2 and sticky status = 0: latch addr/data/op into the request register and go to REQ.
  - `dmi_update` with sticky status ≠ 0: the request is ignored and nothing changes.
  - nop or reserved: no transaction; the current status is kept.
- REQ:
  - `dtm_req_valid`=1, `dtm_req_bits` is stable.
  - On `dtm_req_valid && dtm_req_ready`, go to RESP and clear the timeout counter.
- RESP:
  - `dm_resp_ready`=1 and the counter increments each cycle.
  - On `dm_resp_valid`, go to IDLE. Latch `dm_resp_bits` data (read only; write keeps the previous data). A response status of 2 or 3 sets sticky = 2. Any other response status leaves sticky unchanged.
  - If the counter reaches TIMEOUT with no response, set sticky = 2 and go to IDLE.
- `dmi_update` while not IDLE: sticky = 3. The request is dropped and the in-flight transaction continues.
- `dmi_rdata` status: sticky if ≠ 0; otherwise 3 if not IDLE; otherwise 0.
- `dmi_capture` while not IDLE with sticky = 0: sticky = 3.
- The address field of `dmi_rdata` is the address of the last request issued.
- `dmireset`: sticky = 0. It takes priority over a same-cycle busy or fail set. The FSM is unaffected.
- `dmihardreset`: FSM → IDLE, sticky = 0, counter = 0, and `dtm_req_valid`/`dm_resp_ready` drop the next cycle. A response arriving later is ignored (`dm_resp_ready` is 0).
- Simultaneous `dmi_update` and `dmi_capture`: capture sees the pre-update state.

## Timing
- Reset values: `dtm_req_valid`=0, `dtm_req_bits`=0, `dm_resp_ready`=0, `dmi_rdata`=0, `dmi_busy`=0; FSM=IDLE, sticky=0, counter=0.
- Request path: `dmi_update` in cycle N → `dtm_req_valid`=1 and `dmi_busy`=1 from N+1.
- Handshake: if `dtm_req_ready` is high in N+1, `dm_resp_ready`=1 from N+2.
- Response: `dm_resp_valid` in cycle M → data/status visible on `dmi_rdata` and `dmi_busy`=0 at M+1.
- Minimum transaction is 3 cycles from update to IDLE, with ready and response both immediate.
- All outputs are registered; `dtm_req_bits` changes only on leaving IDLE.
- Timeout: the failure is taken in the TIMEOUT-th RESP cycle without `dm_resp_valid`. A response arriving in that same cycle wins.

## Test plan
- Write: update op=2, addr=0x04, data=0xDEADBEEF; DM ready immediate, resp status 0 → `dtm_req_bits` = {0xDEADBEEF, 0x04, 2'b10}; status 0; IDLE after 3 cycles.
- Read: update op=1, addr=0x04; DM holds ready low 4 cycles, then responds with 0x12345678 → `dtm_req_valid` stays high 5 cycles; `dmi_rdata` = {0x04, 0x12345678, 2'b00}.
- Busy overlap: second update during RESP → status 3, second request never issued. A later update is ignored until `dmireset`, after which it issues.
- Timeout: TIMEOUT=8, DM never responds → status 2 on the 8th RESP cycle. A late `dm_resp_valid` is not acknowledged.
- Hard reset mid-REQ: `dmihardreset` while `dtm_req_valid`=1 → valid 0 next cycle, `dmi_busy`=0, status 0.
- Async reset mid-RESP: `sys_rstn` low → all outputs 0 immediately, without waiting for a clock edge.
